// File: rtl/code_lock_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : code_lock_param                                              |
// | Description : Multi-digit keypad code lock with retry budget, timed        |
// |               lockout and optional auto-relock (CODE_LOCK_AUTORELOCK_EN).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module code_lock_param #(
  parameter int                            DIGIT_W        = 4,
  parameter int                            CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE           = 16'h1234,
  parameter int                            MAX_TRIES      = 3,
  parameter int                            LOCKOUT_CYCLES = 1024,
  parameter int                            RELOCK_CYCLES  = 4096
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enter,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic                               clear,
  input  logic                               relock,
  output logic                               locked_led,
  output logic                               unlocked_led,
  output logic                               error_led,
  output logic [2:0]                         state_leds,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic [$clog2(CODE_LEN+1)-1:0]      digit_count
);

  localparam int c_TW = $clog2(MAX_TRIES + 1);
  localparam int c_CW = $clog2(CODE_LEN + 1);
  localparam int c_LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [c_TW-1:0] c_MAX_TRIES = c_TW'(MAX_TRIES);
  localparam logic [c_CW-1:0] c_LAST      = c_CW'(CODE_LEN - 1);
  localparam logic [c_LW-1:0] c_LOCK_LOAD = c_LW'(LOCKOUT_CYCLES - 1);

  if (CODE_LEN < 1 || MAX_TRIES < 1 || LOCKOUT_CYCLES < 1 || RELOCK_CYCLES < 1 || DIGIT_W < 1)
  begin : g_param_check
    $error("code_lock_param: all size parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_ERROR    = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_enter_q;
  logic [c_TW-1:0]   r_tries, w_tries_nxt;
  logic [c_CW-1:0]   r_digit_count, w_count_nxt;
  logic              r_mismatch, w_mismatch_nxt;
  logic [c_LW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic              r_locked_led, r_unlocked_led, r_error_led;
  logic [2:0]        r_state_leds;
  logic [DIGIT_W-1:0] w_exp_digit;
  logic              w_edge;
  logic              w_mm_any;

`ifdef CODE_LOCK_AUTORELOCK_EN
  localparam int c_RW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [c_RW-1:0] c_RELOCK_LOAD = c_RW'(RELOCK_CYCLES - 1);
  logic [c_RW-1:0]   r_relock_cnt, w_relock_cnt_nxt;
`endif

  assign w_edge   = enter & ~r_enter_q;
  assign w_mm_any = r_mismatch | (digit != w_exp_digit);

  // Digit 0 lives in the most-significant slice of CODE.
  always_comb begin
    w_exp_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_digit_count == c_CW'(i))
        w_exp_digit = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tries_nxt    = r_tries;
    w_count_nxt    = r_digit_count;
    w_mismatch_nxt = r_mismatch;
    w_lock_cnt_nxt = r_lock_cnt;
`ifdef CODE_LOCK_AUTORELOCK_EN
    w_relock_cnt_nxt = r_relock_cnt;
`endif
    case (r_state)
      ST_LOCKED: begin
        if (clear) begin
          w_count_nxt    = '0;
          w_mismatch_nxt = 1'b0;
        end else if (w_edge) begin
          if (r_digit_count >= c_LAST) begin
            w_count_nxt    = '0;
            w_mismatch_nxt = 1'b0;
            if (!w_mm_any) begin
              w_state_nxt = ST_UNLOCKED;
              w_tries_nxt = c_MAX_TRIES;
`ifdef CODE_LOCK_AUTORELOCK_EN
              w_relock_cnt_nxt = c_RELOCK_LOAD;
`endif
            end else if (r_tries > c_TW'(1)) begin
              w_state_nxt = ST_ERROR;
              w_tries_nxt = r_tries - c_TW'(1);
            end else begin
              w_state_nxt    = ST_LOCKOUT;
              w_tries_nxt    = '0;
              w_lock_cnt_nxt = c_LOCK_LOAD;
            end
          end else begin
            w_count_nxt    = r_digit_count + c_CW'(1);
            w_mismatch_nxt = w_mm_any;
          end
        end
      end
      ST_ERROR: begin
        if (clear || w_edge)
          w_state_nxt = ST_LOCKED;
      end
      ST_LOCKOUT: begin
        if (r_lock_cnt == '0) begin
          w_state_nxt = ST_LOCKED;
          w_tries_nxt = c_MAX_TRIES;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - c_LW'(1);
        end
      end
      ST_UNLOCKED: begin
        if (relock) begin
          w_state_nxt = ST_LOCKED;
        end
`ifdef CODE_LOCK_AUTORELOCK_EN
        else if (r_relock_cnt == '0) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_relock_cnt_nxt = r_relock_cnt - c_RW'(1);
        end
`endif
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
  end

  // LED outputs are decoded from the next state so they are true registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_LOCKED;
      r_enter_q      <= 1'b0;
      r_tries        <= c_MAX_TRIES;
      r_digit_count  <= '0;
      r_mismatch     <= 1'b0;
      r_lock_cnt     <= '0;
      r_locked_led   <= 1'b1;
      r_unlocked_led <= 1'b0;
      r_error_led    <= 1'b0;
      r_state_leds   <= 3'd0;
`ifdef CODE_LOCK_AUTORELOCK_EN
      r_relock_cnt   <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_enter_q      <= enter;
      r_tries        <= w_tries_nxt;
      r_digit_count  <= w_count_nxt;
      r_mismatch     <= w_mismatch_nxt;
      r_lock_cnt     <= w_lock_cnt_nxt;
      r_locked_led   <= (w_state_nxt != ST_UNLOCKED);
      r_unlocked_led <= (w_state_nxt == ST_UNLOCKED);
      r_error_led    <= (w_state_nxt == ST_ERROR) || (w_state_nxt == ST_LOCKOUT);
      r_state_leds   <= {1'b0, w_state_nxt};
`ifdef CODE_LOCK_AUTORELOCK_EN
      r_relock_cnt   <= w_relock_cnt_nxt;
`endif
    end
  end

  assign locked_led   = r_locked_led;
  assign unlocked_led = r_unlocked_led;
  assign error_led    = r_error_led;
  assign state_leds   = r_state_leds;
  assign tries_left   = r_tries;
  assign digit_count  = r_digit_count;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_param.sv
`default_nettype none
// Bench for code_lock_param: abstract queue-based model compared every cycle,
// plus literal expectations along the directed sequence.
module tb_code_lock_param;

  localparam int DW = 4;
  localparam int CL = 4;
  localparam int MT = 3;
  localparam int LC = 1024;
  localparam int RC = 8;
  localparam logic [15:0] CODE = 16'h1234;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       clear = 1'b0;
  logic       relock = 1'b0;
  logic       locked_led, unlocked_led, error_led;
  logic [2:0] state_leds;
  logic [1:0] tries_left;
  logic [2:0] digit_count;

  int n_vec = 0;
  int n_err = 0;

  code_lock_param #(
    .DIGIT_W(DW), .CODE_LEN(CL), .CODE(CODE), .MAX_TRIES(MT),
    .LOCKOUT_CYCLES(LC), .RELOCK_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .digit(digit), .clear(clear),
    .relock(relock), .locked_led(locked_led), .unlocked_led(unlocked_led),
    .error_led(error_led), .state_leds(state_leds), .tries_left(tries_left),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_digit(input int i);
    logic [15:0] c;
    c = CODE;
    return int'((c >> ((CL - 1 - i) * DW)) & 16'h000F);
  endfunction

  // Model: 0=LOCKED 1=UNLOCKED 2=ERROR 3=LOCKOUT; entry kept as a digit queue.
  int m_state, m_tries, m_timer, m_rtimer;
  bit m_prev, m_edge, m_ok;
  int m_entry[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_tries = MT; m_timer = 0; m_rtimer = 0; m_prev = 0;
      m_entry.delete();
    end else begin
      m_edge = enter && !m_prev;
      m_prev = enter;
      case (m_state)
        0: begin
          if (clear) m_entry.delete();
          else if (m_edge) begin
            m_entry.push_back(int'(digit));
            if (m_entry.size() == CL) begin
              m_ok = 1;
              foreach (m_entry[i]) if (m_entry[i] != code_digit(i)) m_ok = 0;
              m_entry.delete();
              if (m_ok) begin m_state = 1; m_tries = MT; m_rtimer = RC; end
              else if (m_tries > 1) begin m_state = 2; m_tries = m_tries - 1; end
              else begin m_state = 3; m_tries = 0; m_timer = LC; end
            end
          end
        end
        1: begin
          if (relock) m_state = 0;
`ifdef CODE_LOCK_AUTORELOCK_EN
          else begin
            m_rtimer = m_rtimer - 1;
            if (m_rtimer == 0) m_state = 0;
          end
`endif
        end
        2: if (clear || m_edge) m_state = 0;
        default: begin
          m_timer = m_timer - 1;
          if (m_timer == 0) begin m_state = 0; m_tries = MT; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("locked_led",   int'(locked_led),   int'(m_state != 1));
    chk("unlocked_led", int'(unlocked_led), int'(m_state == 1));
    chk("error_led",    int'(error_led),    int'(m_state >= 2));
    chk("state_leds",   int'(state_leds),   m_state);
    chk("tries_left",   int'(tries_left),   m_tries);
    chk("digit_count",  int'(digit_count),  m_entry.size());
  end

  task automatic press(input int d);
    @(posedge clk); #2;
    digit = 4'(d); enter = 1'b1;
    @(posedge clk); #2;
    enter = 1'b0;
  endtask

  task automatic press4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic pulse_relock();
    @(posedge clk); #2 relock = 1'b1;
    @(posedge clk); #2 relock = 1'b0;
  endtask

  task automatic three_wrong();
    press4(9, 9, 9, 9);
    chk("wrong1_state", int'(state_leds), 2);
    chk("wrong1_tries", int'(tries_left), 2);
    press(0);
    press4(9, 9, 9, 9);
    chk("wrong2_tries", int'(tries_left), 1);
    press(0);
    press4(9, 9, 9, 9);
    chk("lockout_state", int'(state_leds), 3);
    chk("lockout_tries", int'(tries_left), 0);
    chk("lockout_err",   int'(error_led), 1);
  endtask

  int n;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_locked", int'(locked_led), 1);
    chk("rst_state",  int'(state_leds), 0);
    chk("rst_tries",  int'(tries_left), 3);
    chk("rst_count",  int'(digit_count), 0);
    rst_n = 1'b1;

    // Correct code
    press(1); chk("cnt1", int'(digit_count), 1);
    press(2); chk("cnt2", int'(digit_count), 2);
    press(3); chk("cnt3", int'(digit_count), 3);
    press(4);
    chk("unlock_state", int'(state_leds), 1);
    chk("unlock_led",   int'(unlocked_led), 1);
    chk("unlock_tries", int'(tries_left), 3);
    chk("unlock_count", int'(digit_count), 0);
    press(5);
    chk("unlock_ignores_edge", int'(state_leds), 1);
    pulse_relock();
    chk("relock_state", int'(state_leds), 0);

    // Wrong code, then one consumed edge
    press4(1, 2, 9, 4);
    chk("err_state", int'(state_leds), 2);
    chk("err_led",   int'(error_led), 1);
    chk("err_tries", int'(tries_left), 2);
    press(7);
    chk("err_exit_state", int'(state_leds), 0);
    chk("err_exit_count", int'(digit_count), 0);

    // clear together with an edge
    press(1); press(2);
    @(posedge clk); #2;
    clear = 1'b1; enter = 1'b1; digit = 4'd3;
    @(posedge clk); #2;
    clear = 1'b0; enter = 1'b0;
    chk("clear_count", int'(digit_count), 0);
    chk("clear_tries", int'(tries_left), 2);
    press4(1, 2, 3, 4);
    chk("post_clear_unlock", int'(state_leds), 1);
    chk("post_clear_tries",  int'(tries_left), 3);
    pulse_relock();

    // enter held high for 10 cycles
    @(posedge clk); #2;
    digit = 4'd1; enter = 1'b1;
    repeat (10) @(posedge clk);
    #2 enter = 1'b0;
    chk("hold_count", int'(digit_count), 1);
    @(posedge clk); #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0;
    chk("hold_clear", int'(digit_count), 0);

    // Lockout with ignored activity
    three_wrong();
    n = 1;
    for (int k = 0; k < 2000; k++) begin
      enter  = k[1];
      digit  = 4'd1;
      clear  = (k % 7 == 3);
      relock = (k % 11 == 5);
      @(posedge clk); #2;
      if (state_leds != 3'd3) break;
      n++;
    end
    enter = 1'b0; clear = 1'b0; relock = 1'b0;
    chk("lockout_len",   n, LC);
    chk("lockout_exit",  int'(state_leds), 0);
    chk("lockout_tries", int'(tries_left), 3);
    chk("lockout_count", int'(digit_count), 0);

    // Asynchronous reset mid-lockout
    three_wrong();
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state_leds), 0);
    chk("async_rst_tries", int'(tries_left), 3);
    chk("async_rst_led",   int'(locked_led), 1);
    @(posedge clk); #2 rst_n = 1'b1;

    // Relock behaviour
    press4(1, 2, 3, 4);
    chk("final_unlock", int'(state_leds), 1);
`ifdef CODE_LOCK_AUTORELOCK_EN
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (state_leds != 3'd1) break;
      n++;
    end
    chk("autorelock_len",   n, RC);
    chk("autorelock_state", int'(state_leds), 0);
`else
    repeat (10000) @(posedge clk);
    #2 chk("hold_unlocked", int'(state_leds), 1);
    pulse_relock();
    chk("manual_relock", int'(state_leds), 0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_lock_param.md
# code_lock_param

Parametrised successor of the single-digit lock FSM: a multi-digit keypad code lock with a configurable code length, digit width, stored code, retry budget and timed lockout. It sits behind the Tiny Tapeout top-level pin mapping. It takes a digit bus and an `enter` strobe from `ui_in`, and drives the status LEDs and state display on `uo_out`. Mealy digit comparison and Moore state/outputs are merged into one registered block.

## Interface
- `DIGIT_W`, 4: width of one digit.
- `CODE_LEN`, 4: number of digits per code entry, ≥1.
- `CODE`, 16'h1234: stored code, `CODE_LEN*DIGIT_W` bits; digit 0 is the most-significant slice.
- `MAX_TRIES`, 3: wrong entries allowed before lockout, ≥1.
- `LOCKOUT_CYCLES`, 1024: lockout duration in clk cycles, ≥1.
- `RELOCK_CYCLES`, 4096: auto-relock delay; used only with `CODE_LOCK_AUTORELOCK_EN`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enter`, in, 1: level input, synchronous to `clk`; the rising edge accepts `digit`.
- `digit`, in, `DIGIT_W`: digit value, sampled in the cycle of the `enter` rising edge.
- `clear`, in, 1: abandon the partial entry.
- `relock`, in, 1: force UNLOCKED back to LOCKED.
- `locked_led`, out, 1: high in every state except UNLOCKED.
- `unlocked_led`, out, 1: high in UNLOCKED.
- `error_led`, out, 1: high in ERROR and LOCKOUT.
- `state_leds`, out, 3: state code. LOCKED=0, UNLOCKED=1, ERROR=2, LOCKOUT=3.
- `tries_left`, out, `$clog2(MAX_TRIES+1)`: remaining attempts.
- `digit_count`, out, `$clog2(CODE_LEN+1)`: digits accepted in the current entry.

## Operation
Edge detection:
- `enter_q` is a register of `enter`.
- An edge is `enter & ~enter_q`.
- Holding `enter` high produces only one edge.

LOCKED:
- On an edge, compare `digit` with slice `digit_count` of `CODE`.
- A mismatch sets a sticky `mismatch` flag; `digit_count` increments.
- On the edge that supplies digit `CODE_LEN-1`, the result includes the current digit, and the entry is evaluated:
  - All digits matched → UNLOCKED; `tries_left` reloads to `MAX_TRIES`.
  - Any mismatch with `tries_left > 1` → ERROR; `tries_left` decrements.
  - Any mismatch with `tries_left == 1` → LOCKOUT; `tries_left` goes to 0 and the lockout counter loads `LOCKOUT_CYCLES-1`.
- In every case `digit_count` and `mismatch` clear.
- `clear` resets `digit_count` and `mismatch` without consuming a try.
- `clear` together with an edge: `clear` wins and the digit is discarded.

ERROR:
- The next edge is consumed and does not count as a digit; the state returns to LOCKED.
- `clear` also returns to LOCKED.

LOCKOUT:
- All edges, `clear` and `relock` are ignored.
- The counter decrements each cycle.
- In the cycle it reads 0, the state goes to LOCKED and `tries_left` reloads to `MAX_TRIES`.

UNLOCKED:
- Edges and `clear` are ignored.
- `relock` → LOCKED.

Width rule: all counters saturate and never wrap; `digit_count` never exceeds `CODE_LEN-1` in any registered state.

## Timing
Reset values (asynchronous `rst_n` low), also applied mid-entry or mid-lockout:
- state LOCKED, so `locked_led`=1, `unlocked_led`=0, `error_led`=0, `state_leds`=0.
- `tries_left`=`MAX_TRIES`, `digit_count`=0, `mismatch`=0, counters 0, `enter_q`=0.

Latency and sequencing:
- All outputs are registered.
- An edge sampled in cycle N is visible in the state and counters in cycle N+1.
- The final-digit edge in cycle N shows UNLOCKED, ERROR or LOCKOUT in cycle N+1.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles; LOCKED is visible in the following cycle.
- `enter` held high across a state change generates no new edge. A fresh rising edge is required to start the next entry.

## Configuration
`CODE_LOCK_AUTORELOCK_EN`:
- Defined: entering UNLOCKED loads the relock counter with `RELOCK_CYCLES-1`. After `RELOCK_CYCLES` cycles in UNLOCKED the state returns to LOCKED. `relock` still returns to LOCKED immediately.
- Undefined: UNLOCKED is held until `relock` or reset, and no relock counter is synthesised.

## Test plan
- Reset, then edges with digits 1,2,3,4 → `digit_count` 1,2,3 then 0; UNLOCKED one cycle after the 4th edge; `unlocked_led`=1, `tries_left`=3.
- Digits 1,2,9,4 → ERROR, `error_led`=1, `tries_left`=2. One edge → LOCKED, `digit_count`=0.
- Three wrong entries → LOCKOUT with `tries_left`=0. Edges during LOCKOUT are ignored. LOCKED with `tries_left`=3 after exactly 1024 cycles.
- Digits 1,2 then `clear` together with an edge carrying 3 → `digit_count`=0, `tries_left` unchanged; the following entry 1,2,3,4 unlocks.
- `enter` held high 10 cycles → one digit accepted. `rst_n` low mid-lockout → LOCKED, `tries_left`=3 immediately, without waiting for a clock.
- With `CODE_LOCK_AUTORELOCK_EN` and `RELOCK_CYCLES`=8: after unlock, LOCKED exactly 8 cycles later. Without the macro: still UNLOCKED after 10000 cycles until `relock`.
